// File: rtl/mio_bus_pkg.sv
// Shared encodings for the MIO bus arbiter: FSM states, owner ids and the
// default read data returned when the memory never acknowledges.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic        OWN_CPU      = 1'b0;
  localparam logic        OWN_DBG      = 1'b1;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          CNT_W        = 16;

endpackage

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker. Bit 0 of i_req is the CPU, bit 1 is debug.
// With both requesting, the side that did not win last time is chosen.
module rr_arb2
  import mio_bus_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_grant
);

  // Combinational winner selection from the request pair and last winner
  always_comb begin
    o_valid = 1'b0;
    o_grant = OWN_CPU;
    case (i_req)
      2'b01: begin
        o_valid = 1'b1;
        o_grant = OWN_CPU;
      end
      2'b10: begin
        o_valid = 1'b1;
        o_grant = OWN_DBG;
      end
      2'b11: begin
        o_valid = 1'b1;
        o_grant = ~i_last_grant;
      end
      default: begin
        o_valid = 1'b0;
        o_grant = OWN_CPU;
      end
    endcase
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares the data-memory/peripheral bus between the CPU MIO port and a
// debug/DMA requester. Each transfer is granted, driven from latched copies
// of the winner's inputs, waits for the memory ack (or a timeout), returns
// read data and pulses the owner's ready/ack for one cycle.
module mio_bus_arbiter
  import mio_bus_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          owner,
  output logic          timeout_err
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t           r_state,     w_state_nx;
  logic             r_owner,     w_owner_nx;
  logic             r_last,      w_last_nx;
  logic             r_we,        w_we_nx;
  logic [AW-1:0]    r_addr,      w_addr_nx;
  logic [DW-1:0]    r_wdata,     w_wdata_nx;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nx;
  logic [DW-1:0]    r_cpu_rdata, w_cpu_rdata_nx;
  logic [DW-1:0]    r_dbg_rdata, w_dbg_rdata_nx;
  logic             r_cpu_ready, w_cpu_ready_nx;
  logic             r_dbg_ack,   w_dbg_ack_nx;
  logic             r_mem_req,   w_mem_req_nx;
  logic             r_busy,      w_busy_nx;
  logic             r_terr,      w_terr_nx;

  logic             w_gnt_valid;
  logic             w_gnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_end;
  logic [DW-1:0]    w_rd_val;

  rr_arb2 u_rr_arb2 (
    .i_req        ({dbg_req, cpu_req}),
    .i_last_grant (r_last),
    .o_valid      (w_gnt_valid),
    .o_grant      (w_gnt)
  );

  // Next-state and next-output logic for the grant / transfer / done sequence
  always_comb begin
    w_state_nx     = r_state;
    w_owner_nx     = r_owner;
    w_last_nx      = r_last;
    w_we_nx        = r_we;
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
    w_cnt_nx       = r_cnt;
    w_cpu_rdata_nx = r_cpu_rdata;
    w_dbg_rdata_nx = r_dbg_rdata;
    w_cpu_ready_nx = 1'b0;
    w_dbg_ack_nx   = 1'b0;
    w_mem_req_nx   = 1'b0;
    w_busy_nx      = 1'b0;
    w_terr_nx      = r_terr;
    w_cnt_inc      = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    // An ack on the very cycle the counter expires still counts as success
    w_end          = mem_ack || (w_cnt_inc == TO_VAL);
    w_rd_val       = mem_ack ? mem_rdata : ERR_DATA;

    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nx   = XFER;
          w_owner_nx   = w_gnt;
          w_last_nx    = w_gnt;
          w_cnt_nx     = {CNT_W{1'b0}};
          w_mem_req_nx = 1'b1;
          w_busy_nx    = 1'b1;
          if (w_gnt == OWN_DBG) begin
            w_we_nx    = dbg_we;
            w_addr_nx  = dbg_addr;
            w_wdata_nx = dbg_wdata;
          end else begin
            w_we_nx    = cpu_we;
            w_addr_nx  = cpu_addr;
            w_wdata_nx = cpu_wdata;
          end
        end else begin
          w_state_nx = IDLE;
        end
      end

      XFER: begin
        w_busy_nx = 1'b1;
        w_cnt_nx  = w_cnt_inc;
        if (w_end) begin
          w_state_nx     = DONE;
          w_cpu_ready_nx = (r_owner == OWN_CPU);
          w_dbg_ack_nx   = (r_owner == OWN_DBG);
          w_terr_nx      = r_terr | ~mem_ack;
          if (r_we) begin
            w_cpu_rdata_nx = r_cpu_rdata;
          end else if (r_owner == OWN_CPU) begin
            w_cpu_rdata_nx = w_rd_val;
          end else begin
            w_dbg_rdata_nx = w_rd_val;
          end
        end else begin
          w_mem_req_nx = 1'b1;
        end
      end

      DONE: begin
        // Always return through IDLE so transfers are separated by a cycle
        w_state_nx = IDLE;
        w_cnt_nx   = {CNT_W{1'b0}};
      end

      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, latched bus copy, counter and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_CPU;
      r_last      <= OWN_DBG;
      r_we        <= 1'b0;
      r_addr      <= {AW{1'b0}};
      r_wdata     <= {DW{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_cpu_rdata <= {DW{1'b0}};
      r_dbg_rdata <= {DW{1'b0}};
      r_cpu_ready <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_owner     <= w_owner_nx;
      r_last      <= w_last_nx;
      r_we        <= w_we_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
      r_cnt       <= w_cnt_nx;
      r_cpu_rdata <= w_cpu_rdata_nx;
      r_dbg_rdata <= w_dbg_rdata_nx;
      r_cpu_ready <= w_cpu_ready_nx;
      r_dbg_ack   <= w_dbg_ack_nx;
      r_mem_req   <= w_mem_req_nx;
      r_busy      <= w_busy_nx;
      r_terr      <= w_terr_nx;
    end
  end

  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ready   = r_cpu_ready;
  assign dbg_rdata   = r_dbg_rdata;
  assign dbg_ack     = r_dbg_ack;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign busy        = r_busy;
  assign owner       = r_owner;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter (TIMEOUT = 4). A small memory responder
// raises mem_ack in a chosen XFER cycle; monitors count ready/ack pulses and
// mem_req cycles so each scenario can check exact pulse and latency counts.
`timescale 1ns/1ps
module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0BAD_0BAD;
  logic        mem_ack = 1'b0;
  logic        busy, owner, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_at   = 0;
  logic [31:0] rsp_data = 32'h0;
  int req_cycles = 0;
  int n_cpu_rdy = 0, n_dbg_ack = 0, n_memreq = 0;

  mio_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memory model: ack in the ack_at-th cycle of mem_req (0 = never ack)
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      req_cycles = req_cycles + 1;
      if (ack_at != 0 && req_cycles == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rsp_data;
      end else begin
        mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
      end
    end else begin
      req_cycles = 0; mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    end
  end

  // Pulse and mem_req-cycle counters, sampled mid-cycle
  always @(negedge clk) begin
    if (cpu_ready) n_cpu_rdy = n_cpu_rdy + 1;
    if (dbg_ack)   n_dbg_ack = n_dbg_ack + 1;
    if (mem_req)   n_memreq  = n_memreq + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pulse(output logic got, output int cyc);
    got = 1'b0; cyc = 0;
    while (!got && cyc < 20) begin
      step(); cyc++;
      if (cpu_ready || dbg_ack) got = 1'b1;
    end
  endtask

  task automatic apply_reset();
    cpu_req = 1'b0; dbg_req = 1'b0; ack_at = 0;
    rst = 1'b0; step(); step();
    rst = 1'b1; step();
  endtask

  task automatic test_reset();
    rst = 1'b0; step();
    n_checks++; if ({mem_req, busy, cpu_ready, dbg_ack, timeout_err} !== 5'b0) $display("FAIL reset ctrl: got %b want 00000", {mem_req, busy, cpu_ready, dbg_ack, timeout_err}); else n_pass++;
    n_checks++; if (owner !== 1'b0) $display("FAIL reset owner: got %b want 0", owner); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) $display("FAIL reset rdata: got %h/%h want 0/0", cpu_rdata, dbg_rdata); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0 || mem_we !== 1'b0) $display("FAIL reset bus: got %h/%b want 0/0", mem_addr, mem_we); else n_pass++;
    rst = 1'b1; step(); step();
    n_checks++; if (busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL idle no req: got busy=%b mem_req=%b want 0", busy, mem_req); else n_pass++;
  endtask

  task automatic test_cpu_read();
    logic got; int cyc; int s_c, s_d, s_m;
    s_c = n_cpu_rdy; s_d = n_dbg_ack; s_m = n_memreq;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    ack_at = 3; rsp_data = 32'h1234_5678;
    step();
    n_checks++; if (mem_req !== 1'b1 || busy !== 1'b1) $display("FAIL cpu_read grant: got mem_req=%b busy=%b want 1", mem_req, busy); else n_pass++;
    n_checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) $display("FAIL cpu_read bus: got %h/%b want 00000010/0", mem_addr, mem_we); else n_pass++;
    wait_pulse(got, cyc);
    n_checks++; if (got !== 1'b1 || cyc !== 3 || cpu_ready !== 1'b1) $display("FAIL cpu_read ready latency: got %0d cycles ready=%b want 3 cycles", cyc, cpu_ready); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'h1234_5678) $display("FAIL cpu_read rdata: got %h want 12345678", cpu_rdata); else n_pass++;
    cpu_req = 1'b0;
    step();
    n_checks++; if (cpu_ready !== 1'b0 || busy !== 1'b0) $display("FAIL cpu_read after: got ready=%b busy=%b want 0", cpu_ready, busy); else n_pass++;
    n_checks++; if (n_cpu_rdy - s_c !== 1 || n_dbg_ack - s_d !== 0) $display("FAIL cpu_read pulses: got cpu=%0d dbg=%0d want 1/0", n_cpu_rdy - s_c, n_dbg_ack - s_d); else n_pass++;
    n_checks++; if (n_memreq - s_m !== 3) $display("FAIL cpu_read mem_req cycles: got %0d want 3", n_memreq - s_m); else n_pass++;
  endtask

  task automatic test_contention();
    logic got; int cyc; logic exp_own;
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hAAAA_0000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    ack_at = 2; rsp_data = 32'hCAFE_0001;
    for (int g = 0; g < 4; g++) begin
      exp_own = g[0];
      step();
      n_checks++; if (owner !== exp_own || mem_req !== 1'b1) $display("FAIL contention grant %0d: got owner=%b mem_req=%b want owner=%b", g, owner, mem_req, exp_own); else n_pass++;
      n_checks++; if (mem_addr !== (exp_own ? 32'h40 : 32'h20) || mem_we !== ~exp_own) $display("FAIL contention bus %0d: got %h/%b", g, mem_addr, mem_we); else n_pass++;
      if (!exp_own) begin
        n_checks++; if (mem_wdata !== 32'hAAAA_0000) $display("FAIL contention wdata %0d: got %h want aaaa0000", g, mem_wdata); else n_pass++;
      end
      wait_pulse(got, cyc);
      n_checks++; if (got !== 1'b1 || {dbg_ack, cpu_ready} !== (exp_own ? 2'b10 : 2'b01)) $display("FAIL contention pulse %0d: got dbg=%b cpu=%b", g, dbg_ack, cpu_ready); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL contention idle gap %0d: got busy=%b mem_req=%b want 0", g, busy, mem_req); else n_pass++;
    end
    n_checks++; if (dbg_rdata !== 32'hCAFE_0001 || cpu_rdata !== 32'h0) $display("FAIL contention rdata: got dbg=%h cpu=%h want cafe0001/0", dbg_rdata, cpu_rdata); else n_pass++;
    cpu_req = 1'b0; dbg_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    logic got; int cyc; int s_m, s_c;
    s_m = n_memreq; s_c = n_cpu_rdy;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h80; ack_at = 0;
    wait_pulse(got, cyc);
    n_checks++; if (got !== 1'b1 || dbg_ack !== 1'b1 || cyc !== 5) $display("FAIL timeout ack: got ack=%b after %0d cycles want 1 after 5", dbg_ack, cyc); else n_pass++;
    n_checks++; if (dbg_rdata !== 32'hDEAD_BEEF) $display("FAIL timeout rdata: got %h want deadbeef", dbg_rdata); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout err: got %b want 1", timeout_err); else n_pass++;
    dbg_req = 1'b0;
    step();
    n_checks++; if (n_memreq - s_m !== 4 || n_cpu_rdy - s_c !== 0) $display("FAIL timeout mem_req cycles: got %0d cpu pulses %0d want 4/0", n_memreq - s_m, n_cpu_rdy - s_c); else n_pass++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h84; ack_at = 1; rsp_data = 32'h0000_1111;
    wait_pulse(got, cyc);
    n_checks++; if (got !== 1'b1 || cpu_rdata !== 32'h0000_1111) $display("FAIL timeout good read: got %h want 00001111", cpu_rdata); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout sticky: got %b want 1", timeout_err); else n_pass++;
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic got; int cyc; int s_c;
    s_c = n_cpu_rdy;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; ack_at = 0;
    step(); step();
    n_checks++; if (mem_req !== 1'b1) $display("FAIL reset_mid pre: got mem_req=%b want 1", mem_req); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if ({mem_req, busy, cpu_ready, timeout_err} !== 4'b0) $display("FAIL reset_mid async: got %b want 0000", {mem_req, busy, cpu_ready, timeout_err}); else n_pass++;
    step();
    rst = 1'b1; ack_at = 2; rsp_data = 32'h7777_0000;
    wait_pulse(got, cyc);
    n_checks++; if (got !== 1'b1 || cyc !== 3 || cpu_rdata !== 32'h7777_0000) $display("FAIL reset_mid recover: got %h after %0d cycles want 77770000 after 3", cpu_rdata, cyc); else n_pass++;
    cpu_req = 1'b0;
    step();
    n_checks++; if (n_cpu_rdy - s_c !== 1) $display("FAIL reset_mid pulses: got %0d want 1", n_cpu_rdy - s_c); else n_pass++;
  endtask

  task automatic test_ack_on_timeout();
    logic got; int cyc; int s_m;
    apply_reset();
    s_m = n_memreq;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60; ack_at = 4; rsp_data = 32'h5555_5555;
    wait_pulse(got, cyc);
    n_checks++; if (got !== 1'b1 || cyc !== 5 || cpu_rdata !== 32'h5555_5555) $display("FAIL ack_on_timeout rdata: got %h after %0d want 55555555 after 5", cpu_rdata, cyc); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL ack_on_timeout err: got %b want 0", timeout_err); else n_pass++;
    cpu_req = 1'b0;
    step();
    n_checks++; if (n_memreq - s_m !== 4) $display("FAIL ack_on_timeout mem_req cycles: got %0d want 4", n_memreq - s_m); else n_pass++;
  endtask

  task automatic test_input_churn();
    logic got; int cyc; int s_c;
    s_c = n_cpu_rdy;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h0F0F_0F0F; ack_at = 3;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h99; cpu_wdata = 32'hFFFF_FFFF;
    step();
    n_checks++; if (mem_addr !== 32'h30 || mem_wdata !== 32'h0F0F_0F0F || mem_we !== 1'b1) $display("FAIL churn bus: got %h/%h/%b want 00000030/0f0f0f0f/1", mem_addr, mem_wdata, mem_we); else n_pass++;
    wait_pulse(got, cyc);
    n_checks++; if (got !== 1'b1 || cpu_ready !== 1'b1) $display("FAIL churn ready: got %b want 1", cpu_ready); else n_pass++;
    step(); step();
    n_checks++; if (n_cpu_rdy - s_c !== 1 || busy !== 1'b0) $display("FAIL churn pulses: got %0d busy=%b want 1/0", n_cpu_rdy - s_c, busy); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'h5555_5555) $display("FAIL churn rdata hold: got %h want 55555555", cpu_rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_ack_on_timeout();
    test_input_churn();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
